gobang_line_scorer: RTL and testbench
=====================================

Name: gobang_line_scorer

Overview:
- Parametrised successor to the fixed-width gobang Score block.
- Scores one board line (row, column or diagonal) streamed in one cell per cycle.
- Slides a WIN_LEN window along the line and sums pattern weights separately for own and opponent stones; flags five-in-a-row.
- Sits between the board-scan controller and the move-evaluation search logic.

Parameters:
- BOARD_N, 15, maximum cells per line; a line is force-terminated at this count.
- WIN_LEN, 5, window length (stones needed to win); legal range 2..8.
- SCORE_W, 25, width of each score accumulator.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  begin a new line; honoured only in IDLE
- i_cell_valid  in  1  cell handshake valid
- i_cell  in  2  cell code: 0 EMPTY, 1 OWN, 2 OPP, 3 BORDER
- i_cell_last  in  1  marks the final cell of the line
- o_cell_ready  out  1  cell handshake ready
- o_score_own  out  SCORE_W  own-stone score of the last completed line
- o_score_opp  out  SCORE_W  opponent score of the last completed line
- o_five_own  out  1  some window held WIN_LEN OWN stones
- o_five_opp  out  1  some window held WIN_LEN OPP stones
- o_busy  out  1  high from start until done
- o_done  out  1  one-cycle pulse when results are valid

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, window cleared. Reset mid-line abandons the line; no o_done is produced.
- States:
  - IDLE: i_start goes to SCAN, clears accumulators, flags and cell count. o_busy rises next cycle.
  - SCAN: o_cell_ready=1. A cell transfers when valid && ready. The window shift register and cell count update on each transfer. Goes to FLUSH on a transfer with i_cell_last, or on the transfer that brings the count to BOARD_N.
  - FLUSH: o_cell_ready=0; drains the single evaluation pipeline stage; then goes to DONE.
  - DONE: o_done=1 for one cycle, o_busy=0; then IDLE.
- Window evaluation:
  - Evaluated once cell count >= WIN_LEN, after each accepted cell, over the last WIN_LEN cells. The result is registered once; the accumulator adds it next cycle.
  - Window contains BORDER, or contains both OWN and OPP: contributes 0.
  - Otherwise c = number of OWN (or OPP) stones; adds weight[c] to that side.
  - Weights: weight[0]=0, weight[c]=10^(c-1), weight[WIN_LEN]=100000 (defaults 1, 10, 100, 1000, 100000).
  - c==WIN_LEN sets the matching o_five flag, which stays set until the next start.
- Latency: o_done is asserted exactly 2 cycles after the clock edge accepting the last cell.
- Short line (fewer than WIN_LEN cells): both scores 0, flags 0, done timing unchanged.
- i_start outside IDLE is ignored. Cells offered outside SCAN are not accepted (ready=0).
- Outputs hold their values after DONE until the next i_start clears them.
- Cell count width is $clog2(BOARD_N+1). The window is WIN_LEN x 2 bits.

Optional Feature:
- Macro GOBANG_SCORE_SAT_EN.
- Defined: each accumulator saturates at 2^SCORE_W-1.
- Undefined: accumulators wrap modulo 2^SCORE_W.

Decomposition:
- Package gobang_pkg holds:
  - cell_t enum (EMPTY, OWN, OPP, BORDER)
  - scorer state enum
  - weight function/constant table indexed by stone count
- Sub-module gobang_window_eval: combinational. Takes a WIN_LEN-cell window and outputs own weight, opp weight, five_own and five_opp.

Test Plan:
- Own run: 15 cells, OWN x5 then EMPTY x10 -> o_score_own=101111, o_score_opp=0, o_five_own=1, o_done 2 cycles after last cell.
- Opp three: 15 cells, EMPTY EMPTY OPP OPP OPP then EMPTY x10 -> o_score_opp=311, own=0, flags 0.
- Border/mixed: 7 cells OWN OWN OWN BORDER OWN OWN OWN with last -> both scores 0. 5 cells OWN OPP EMPTY EMPTY EMPTY -> 0.
- Short line and backpressure:
  - 3 cells, last on the third -> scores 0, o_done 2 cycles later.
  - o_cell_ready=0 in IDLE, FLUSH and DONE.
  - i_start during SCAN is ignored.
- Force-terminate and reset: 15 EMPTY cells with no i_cell_last -> FLUSH after the 15th. Assert i_rst_n=0 mid-line -> all outputs 0 immediately and no o_done.
- Saturation with SCORE_W=17 and 15 OWN cells:
  - raw 11x100000 saturates to 131071 with GOBANG_SCORE_SAT_EN.
  - without it the result is 1100000 mod 131072 = 51424.

Source files
------------

// File: rtl/gobang_pkg.sv
// Shared types and pattern weights for the gobang line scorer.
package gobang_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    OWN    = 2'd1,
    OPP    = 2'd2,
    BORDER = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WEIGHT_W = 32;
  localparam logic [WEIGHT_W-1:0] FIVE_WEIGHT = 32'd100000;

  // weight[0]=0, weight[c]=10^(c-1), weight[win_len]=100000; meant for constant arguments.
  function automatic logic [WEIGHT_W-1:0] weight_of(input int unsigned c, input int unsigned win_len);
    logic [WEIGHT_W-1:0] w;
    w = 32'd1;
    for (int unsigned i = 1; i < c; i++) begin
      w = w * 32'd10;
    end
    if (c == 0) begin
      w = '0;
    end else if (c >= win_len) begin
      w = FIVE_WEIGHT;
    end
    return w;
  endfunction

endpackage

// File: rtl/gobang_window_eval.sv
// Combinational evaluation of one WIN_LEN-cell window: per-side weight and five flags.
module gobang_window_eval
  import gobang_pkg::*;
#(
  parameter int WIN_LEN = 5
) (
  input  logic [2*WIN_LEN-1:0] i_window,
  output logic [WEIGHT_W-1:0]  o_own_w,
  output logic [WEIGHT_W-1:0]  o_opp_w,
  output logic                 o_five_own,
  output logic                 o_five_opp
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);

  cell_t               cells [WIN_LEN];
  logic [WEIGHT_W-1:0] wtab  [WIN_LEN+1];
  logic [CNT_W-1:0]    n_own;
  logic [CNT_W-1:0]    n_opp;
  logic                has_border;
  logic                blocked;

  genvar gi;
  generate
    for (gi = 0; gi < WIN_LEN; gi++) begin : g_cells
      assign cells[gi] = cell_t'(i_window[2*gi +: 2]);
    end
    for (gi = 0; gi <= WIN_LEN; gi++) begin : g_wtab
      assign wtab[gi] = weight_of(gi, WIN_LEN);
    end
  endgenerate

  always_comb begin
    n_own      = '0;
    n_opp      = '0;
    has_border = 1'b0;
    for (int i = 0; i < WIN_LEN; i++) begin
      if (cells[i] == OWN)    n_own = n_own + CNT_W'(1);
      if (cells[i] == OPP)    n_opp = n_opp + CNT_W'(1);
      if (cells[i] == BORDER) has_border = 1'b1;
    end
  end

  // A window that is cut by the border or shared by both sides can never become a five.
  assign blocked    = has_border || ((n_own != '0) && (n_opp != '0));
  assign o_own_w    = blocked ? '0 : wtab[n_own];
  assign o_opp_w    = blocked ? '0 : wtab[n_opp];
  assign o_five_own = !blocked && (n_own == CNT_W'(WIN_LEN));
  assign o_five_opp = !blocked && (n_opp == CNT_W'(WIN_LEN));

endmodule

// File: rtl/gobang_line_scorer.sv
// Streams one board line, scores every WIN_LEN window per side and flags fives.
// Build option: GOBANG_SCORE_SAT_EN makes the score accumulators saturate instead of wrap.
module gobang_line_scorer
  import gobang_pkg::*;
#(
  parameter int BOARD_N = 15,
  parameter int WIN_LEN = 5,
  parameter int SCORE_W = 25
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_cell_valid,
  input  logic [1:0]         i_cell,
  input  logic               i_cell_last,
  output logic               o_cell_ready,
  output logic [SCORE_W-1:0] o_score_own,
  output logic [SCORE_W-1:0] o_score_opp,
  output logic               o_five_own,
  output logic               o_five_opp,
  output logic               o_busy,
  output logic               o_done
);

  localparam int CNT_W = $clog2(BOARD_N + 1);
  localparam int SUM_W = ((SCORE_W > WEIGHT_W) ? SCORE_W : WEIGHT_W) + 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIN_LEN-1:0] window_q, window_d;
  logic                 xfer_q, xfer_d;
  logic                 eval_vld_q, eval_vld_d;
  logic [WEIGHT_W-1:0]  eval_own_q, eval_own_d;
  logic [WEIGHT_W-1:0]  eval_opp_q, eval_opp_d;
  logic                 eval_five_own_q, eval_five_own_d;
  logic                 eval_five_opp_q, eval_five_opp_d;
  logic [SCORE_W-1:0]   score_own_q, score_own_d;
  logic [SCORE_W-1:0]   score_opp_q, score_opp_d;
  logic                 five_own_q, five_own_d;
  logic                 five_opp_q, five_opp_d;

  logic                 xfer;
  logic [WEIGHT_W-1:0]  win_own_w;
  logic [WEIGHT_W-1:0]  win_opp_w;
  logic                 win_five_own;
  logic                 win_five_opp;

  gobang_window_eval #(
    .WIN_LEN(WIN_LEN)
  ) u_eval (
    .i_window  (window_q),
    .o_own_w   (win_own_w),
    .o_opp_w   (win_opp_w),
    .o_five_own(win_five_own),
    .o_five_opp(win_five_opp)
  );

  function automatic logic [SCORE_W-1:0] acc_add(input logic [SCORE_W-1:0] acc,
                                                 input logic [WEIGHT_W-1:0] w);
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] res;
    sum = SUM_W'(acc) + SUM_W'(w);
    res = sum[SCORE_W-1:0];
`ifdef GOBANG_SCORE_SAT_EN
    if (|sum[SUM_W-1:SCORE_W]) res = '1;
`endif
    return res;
  endfunction

  assign xfer = (state_q == ST_SCAN) && i_cell_valid;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    window_d        = window_q;
    xfer_d          = xfer;
    // The window only holds a full set of line cells once WIN_LEN cells have arrived.
    eval_vld_d      = xfer_q && (int'(cnt_q) >= WIN_LEN);
    eval_own_d      = win_own_w;
    eval_opp_d      = win_opp_w;
    eval_five_own_d = win_five_own;
    eval_five_opp_d = win_five_opp;
    score_own_d     = score_own_q;
    score_opp_d     = score_opp_q;
    five_own_d      = five_own_q;
    five_opp_d      = five_opp_q;

    if (eval_vld_q) begin
      score_own_d = acc_add(score_own_q, eval_own_q);
      score_opp_d = acc_add(score_opp_q, eval_opp_q);
      five_own_d  = five_own_q | eval_five_own_q;
      five_opp_d  = five_opp_q | eval_five_opp_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d     = ST_SCAN;
          cnt_d       = '0;
          window_d    = '0;
          score_own_d = '0;
          score_opp_d = '0;
          five_own_d  = 1'b0;
          five_opp_d  = 1'b0;
        end
      end
      ST_SCAN: begin
        if (xfer) begin
          window_d = {window_q[2*WIN_LEN-3:0], i_cell};
          cnt_d    = cnt_q + CNT_W'(1);
          if (i_cell_last || (cnt_q == CNT_W'(BOARD_N - 1))) state_d = ST_FLUSH;
        end
      end
      // Wait one cycle for the final window to be registered, then let it accumulate.
      ST_FLUSH: begin
        if (!xfer_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      window_q        <= '0;
      xfer_q          <= 1'b0;
      eval_vld_q      <= 1'b0;
      eval_own_q      <= '0;
      eval_opp_q      <= '0;
      eval_five_own_q <= 1'b0;
      eval_five_opp_q <= 1'b0;
      score_own_q     <= '0;
      score_opp_q     <= '0;
      five_own_q      <= 1'b0;
      five_opp_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      window_q        <= window_d;
      xfer_q          <= xfer_d;
      eval_vld_q      <= eval_vld_d;
      eval_own_q      <= eval_own_d;
      eval_opp_q      <= eval_opp_d;
      eval_five_own_q <= eval_five_own_d;
      eval_five_opp_q <= eval_five_opp_d;
      score_own_q     <= score_own_d;
      score_opp_q     <= score_opp_d;
      five_own_q      <= five_own_d;
      five_opp_q      <= five_opp_d;
    end
  end

  assign o_cell_ready = (state_q == ST_SCAN);
  assign o_busy       = (state_q == ST_SCAN) || (state_q == ST_FLUSH);
  assign o_done       = (state_q == ST_DONE);
  assign o_score_own  = score_own_q;
  assign o_score_opp  = score_opp_q;
  assign o_five_own   = five_own_q;
  assign o_five_opp   = five_opp_q;

endmodule

// File: tb/tb_gobang_line_scorer.sv
// Scoreboard bench: driver queues the hand-computed result per line, a monitor checks it on o_done.
module tb_gobang_line_scorer;
  import gobang_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_cell_valid, i_cell_last;
  logic [1:0]  i_cell;

  logic        o_cell_ready, o_five_own, o_five_opp, o_busy, o_done;
  logic [24:0] o_score_own, o_score_opp;
  logic        r17_ready, r17_five_own, r17_five_opp, r17_busy, r17_done;
  logic [16:0] r17_own, r17_opp;

  always #5 clk = ~clk;

  gobang_line_scorer u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_cell_valid(i_cell_valid),
    .i_cell(i_cell), .i_cell_last(i_cell_last), .o_cell_ready(o_cell_ready),
    .o_score_own(o_score_own), .o_score_opp(o_score_opp), .o_five_own(o_five_own),
    .o_five_opp(o_five_opp), .o_busy(o_busy), .o_done(o_done)
  );

  gobang_line_scorer #(.SCORE_W(17)) u_dut17 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_cell_valid(i_cell_valid),
    .i_cell(i_cell), .i_cell_last(i_cell_last), .o_cell_ready(r17_ready),
    .o_score_own(r17_own), .o_score_opp(r17_opp), .o_five_own(r17_five_own),
    .o_five_opp(r17_five_opp), .o_busy(r17_busy), .o_done(r17_done)
  );

  typedef struct {
    string name;
    int    own;
    int    opp;
    bit    f_own;
    bit    f_opp;
    int    own17;
    int    opp17;
    int    done_cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         prev_own = 0;
  int         prev_opp = 0;
  logic [1:0] line_c [15];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic int narrow17(input int v);
`ifdef GOBANG_SCORE_SAT_EN
    return (v > 131071) ? 131071 : v;
`else
    return v % 131072;
`endif
  endfunction

  task automatic fill(input int from, input int len, input logic [1:0] v);
    for (int i = from; i < from + len; i++) line_c[i] = v;
  endtask

  // Monitor: every o_done must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && o_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_own"},      o_score_own,  e.own);
        check({e.name, "_opp"},      o_score_opp,  e.opp);
        check({e.name, "_five_own"}, o_five_own,   e.f_own);
        check({e.name, "_five_opp"}, o_five_opp,   e.f_opp);
        check({e.name, "_own17"},    r17_own,      e.own17);
        check({e.name, "_opp17"},    r17_opp,      e.opp17);
        check({e.name, "_done17"},   r17_done,     1);
        check({e.name, "_done_cyc"}, cyc,          e.done_cyc);
        check({e.name, "_done_rdy"}, o_cell_ready, 0);
        check({e.name, "_done_bsy"}, o_busy,       0);
        $display("line %s: own=%0d opp=%0d five=%0b/%0b own17=%0d at cycle %0d",
                 e.name, o_score_own, o_score_opp, o_five_own, o_five_opp, r17_own, cyc);
      end
    end
  end

  task automatic run_line(input string nm, input int n, input bit last_flag, input int glitch_at,
                          input int own, input int opp, input bit f_own, input bit f_opp);
    exp_t e;
    int   acc_cyc;
    int   g;
    acc_cyc = 0;
    @(negedge clk);
    check({nm, "_hold_own"},   o_score_own,  prev_own);
    check({nm, "_hold_opp"},   o_score_opp,  prev_opp);
    check({nm, "_idle_ready"}, o_cell_ready, 0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({nm, "_busy"}, o_busy, 1);
    for (int i = 0; i < n; i++) begin
      if (i % 4 == 3) begin
        i_cell_valid = 1'b0;
        @(negedge clk);
      end
      i_cell_valid = 1'b1;
      i_cell       = line_c[i];
      i_cell_last  = last_flag && (i == n - 1);
      i_start      = (i == glitch_at);
      g = 0;
      while (!o_cell_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (!o_cell_ready) check({nm, "_ready_timeout"}, 0, 1);
      acc_cyc = cyc + 1;
      @(negedge clk);
    end
    i_cell_valid = 1'b0;
    i_cell_last  = 1'b0;
    i_start      = 1'b0;
    e.name = nm; e.own = own; e.opp = opp; e.f_own = f_own; e.f_opp = f_opp;
    e.own17 = narrow17(own); e.opp17 = narrow17(opp); e.done_cyc = acc_cyc + 2;
    sb_q.push_back(e);
    check({nm, "_flush_ready"}, o_cell_ready, 0);
    check({nm, "_flush_busy"},  o_busy,       1);
    g = 0;
    while (sb_q.size() != 0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() != 0) begin
      check({nm, "_done_timeout"}, 0, 1);
      sb_q.delete();
    end
    prev_own = own;
    prev_opp = opp;
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_cell_valid = 1'b0; i_cell = 2'd0; i_cell_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_own",   o_score_own,  0);
    check("rst_five",  o_five_own,   0);
    check("rst_busy",  o_busy,       0);
    check("rst_done",  o_done,       0);
    check("rst_ready", o_cell_ready, 0);
    rst_n = 1'b1;

    fill(0, 15, EMPTY); fill(0, 5, OWN);
    run_line("own_run", 15, 1'b1, -1, 101111, 0, 1'b1, 1'b0);

    fill(0, 15, EMPTY); fill(2, 3, OPP);
    run_line("opp_three", 15, 1'b1, 6, 0, 311, 1'b0, 1'b0);

    fill(0, 7, OWN); line_c[3] = BORDER;
    run_line("border", 7, 1'b1, -1, 0, 0, 1'b0, 1'b0);

    fill(0, 5, EMPTY); line_c[0] = OWN; line_c[1] = OPP;
    run_line("mixed", 5, 1'b1, -1, 0, 0, 1'b0, 1'b0);

    fill(0, 3, OWN);
    run_line("short", 3, 1'b1, -1, 0, 0, 1'b0, 1'b0);

    fill(0, 15, EMPTY);
    run_line("force_term", 15, 1'b0, -1, 0, 0, 1'b0, 1'b0);

    fill(0, 15, OWN);
    run_line("all_own", 15, 1'b1, -1, 1100000, 0, 1'b1, 1'b0);

    fill(0, 15, EMPTY); fill(10, 5, OPP);
    run_line("opp_five", 15, 1'b1, -1, 0, 101111, 1'b0, 1'b1);

    // Abandon a line with a partial score by asserting reset between edges.
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_cell_valid = 1'b1;
      i_cell       = OWN;
      @(negedge clk);
    end
    check("pre_rst_own", (o_score_own != 0) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_own",   o_score_own,  0);
    check("midrst_own17", r17_own,      0);
    check("midrst_five",  o_five_own,   0);
    check("midrst_busy",  o_busy,       0);
    check("midrst_ready", o_cell_ready, 0);
    check("midrst_done",  o_done,       0);
    i_cell_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_own = 0;
    prev_opp = 0;
    repeat (4) @(negedge clk);
    check("post_rst_idle_busy", o_busy, 0);

    fill(0, 15, EMPTY); fill(2, 3, OPP);
    run_line("after_rst", 15, 1'b1, -1, 0, 311, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
